sr_mdu: RTL

SR_MDU -- requirements
Module: sr_mdu

---
 rtl/sr_mdu_if.sv | 26 ++
 rtl/sr_mdu.sv | 112 +++++++++++
 2 files changed

// File: rtl/sr_mdu_if.sv
// sr_mdu_if -- request/response bundle for the sequential multiply/divide unit.
//   req_valid/req_ready : request handshake (master drives valid, slave ready)
//   srcA, srcB, oper    : operands and operation code, sampled on acceptance
//   rsp_valid/rsp_ready : response handshake (slave drives valid, master ready)
//   result, zero        : registered result and its zero flag
interface sr_mdu_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [2:0]  oper;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] result;
   logic        zero;

   modport master (
      output req_valid, srcA, srcB, oper, rsp_ready,
      input  req_ready, rsp_valid, result, zero
   );

   modport slave (
      input  req_valid, srcA, srcB, oper, rsp_ready,
      output req_ready, rsp_valid, result, zero
   );
endinterface

// File: rtl/sr_mdu.sv
// sr_mdu -- 32-bit sequential unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sr_mdu_if.slave -- request/response handshake, operands, result, zero
// One bit per cycle over 32 BUSY cycles; illegal opcodes and division by zero
// complete in a single cycle.
module sr_mdu (
   input logic     clk,
   input logic     rst,
   sr_mdu_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nx;
   logic [63:0] acc;       // product, or {remainder, dividend/quotient}
   logic [31:0] opq;       // multiplicand or divisor
   logic [1:0]  op;        // captured oper[1:0]; oper[2] is never legal
   logic [5:0]  cnt;
   logic [31:0] result_q;
   logic [63:0] acc_nx;
   logic [32:0] mul_sum;
   logic [32:0] div_trial;
   logic [63:0] div_sh;
   logic        fast;

   // Illegal opcode or divide by zero finishes without iterating.
   assign fast = bus.oper[2] | (bus.oper[1] & (bus.srcB == '0));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.req_valid) state_nx = fast ? DONE : BUSY;
         BUSY: if (cnt == 6'd31) state_nx = DONE;
         DONE: if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- handshake outputs ----------------
   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == DONE);
   end

   // ---------------- one iteration step ----------------
   always_comb begin
      // Multiply: add multiplicand into the high half when the current
      // multiplier bit is set, then shift the 65-bit {carry, acc} right.
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opq} : 33'd0);
      // Restoring divide: shift {rem, dividend} left, trial-subtract divisor.
      // The bit shifted out of acc[63] must take part in the compare.
      div_sh    = {acc[62:0], 1'b0};
      div_trial = {acc[63], div_sh[63:32]} - {1'b0, opq};
      acc_nx    = {mul_sum, acc[31:1]};
      if (op[1]) begin
         if (div_trial[32]) acc_nx = div_sh;
         else               acc_nx = {div_trial[31:0], div_sh[31:1], 1'b1};
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         opq      <= '0;
         op       <= '0;
         cnt      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op  <= bus.oper[1:0];
                  cnt <= '0;
                  if (bus.oper[2])
                     result_q <= '0;
                  else if (bus.oper[1] && (bus.srcB == '0))
                     result_q <= bus.oper[0] ? bus.srcA : '1;
                  else if (bus.oper[1]) begin
                     acc <= {32'd0, bus.srcA};
                     opq <= bus.srcB;
                  end else begin
                     acc <= {32'd0, bus.srcB};
                     opq <= bus.srcA;
                  end
               end
            end
            BUSY: begin
               acc <= acc_nx;
               cnt <= cnt + 6'd1;
               // The last step writes the result straight from the step
               // output so DONE is reached after exactly 32 BUSY cycles.
               if (cnt == 6'd31)
                  result_q <= op[0] ? acc_nx[63:32] : acc_nx[31:0];
            end
            default: ;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.zero   = (result_q == '0);

endmodule
